// File: rtl/crossword_grid_entry.sv
// Crossword letter-entry stage: turns keyboard events at the highlighted cell
// into writes on a 5x5 letter grid, with a one-cell-per-cycle clear-all sweep.
module crossword_grid_entry #(
  parameter int GRID_DIM  = 5,
  parameter int CELL_SIZE = 80,
  parameter int X_ORIGIN  = 4,
  parameter int Y_ORIGIN  = 80
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] highlightX,
  input  logic [9:0] highlightY,
  input  logic [2:0] rd_row,
  input  logic [2:0] rd_col,
  output logic [4:0] rd_letter,
  output logic [4:0] filled_count,
  output logic       grid_full,
  output logic       busy,
  output logic       key_accept
);

  localparam int NUM_CELLS = GRID_DIM * GRID_DIM;

  localparam logic [7:0] KEY_A      = 8'h04;
  localparam logic [7:0] KEY_Z      = 8'h1D;
  localparam logic [7:0] KEY_ESC    = 8'h29;
  localparam logic [7:0] KEY_BKSP   = 8'h2A;
  localparam logic [7:0] KEY_DELETE = 8'h4C;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  prevKey_q;
  logic        s1Valid_q, s1Valid_d;
  logic [7:0]  s1Key_q, s1Key_d;
  logic [9:0]  s1X_q, s1X_d;
  logic [9:0]  s1Y_q, s1Y_d;
  logic [4:0]  sweepIdx_q, sweepIdx_d;
  logic [4:0]  cells_q [NUM_CELLS];
  logic [4:0]  cells_d [NUM_CELLS];
  logic [4:0]  count_q, count_d;
  logic        full_q, full_d;
  logic        accept_q, accept_d;

  logic        keyEvent;
  logic        colHit, rowHit, posValid;
  logic [2:0]  colIdx, rowIdx;
  logic [4:0]  cellIdx;

  // A new key is a non-zero keycode that differs from last cycle's keycode.
  assign keyEvent = (keycode != 8'h00) && (keycode != prevKey_q);

  // Stage-1 capture: only events seen while idle enter; the sweep flushes it.
  always_comb begin
    s1Valid_d = 1'b0;
    s1Key_d   = s1Key_q;
    s1X_d     = s1X_q;
    s1Y_d     = s1Y_q;
    if (state_q == IDLE && keyEvent) begin
      s1Valid_d = 1'b1;
      s1Key_d   = keycode;
      s1X_d     = highlightX;
      s1Y_d     = highlightY;
    end
  end

  // Key history and stage-1 registers; history tracks even during the sweep.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      prevKey_q <= 8'h00;
      s1Valid_q <= 1'b0;
      s1Key_q   <= 8'h00;
      s1X_q     <= '0;
      s1Y_q     <= '0;
    end else begin
      prevKey_q <= keycode;
      s1Valid_q <= s1Valid_d;
      s1Key_q   <= s1Key_d;
      s1X_q     <= s1X_d;
      s1Y_q     <= s1Y_d;
    end
  end

  // Pixel-to-cell decode by exact equality against each cell origin.
  always_comb begin
    colHit = 1'b0;
    rowHit = 1'b0;
    colIdx = '0;
    rowIdx = '0;
    for (int k = 0; k < GRID_DIM; k++) begin
      if (s1X_q == 10'(X_ORIGIN + k * CELL_SIZE)) begin
        colHit = 1'b1;
        colIdx = 3'(k);
      end
      if (s1Y_q == 10'(Y_ORIGIN + k * CELL_SIZE)) begin
        rowHit = 1'b1;
        rowIdx = 3'(k);
      end
    end
    posValid = colHit && rowHit;
    cellIdx  = 5'(rowIdx) * 5'(GRID_DIM) + 5'(colIdx);
  end

  // Stage-2 action and clear-sweep FSM: next grid, count, pulse and state.
  always_comb begin
    state_d    = state_q;
    sweepIdx_d = sweepIdx_q;
    cells_d    = cells_q;
    count_d    = count_q;
    accept_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s1Valid_q) begin
          if (s1Key_q == KEY_ESC) begin
            state_d    = CLEAR;
            sweepIdx_d = '0;
            accept_d   = 1'b1;
          end else if (posValid) begin
            if (s1Key_q >= KEY_A && s1Key_q <= KEY_Z) begin
              if (cells_q[cellIdx] == 5'd0) begin
                count_d = count_q + 5'd1;
              end
              cells_d[cellIdx] = 5'(s1Key_q - 8'h03);
              accept_d         = 1'b1;
            end else if (s1Key_q == KEY_BKSP || s1Key_q == KEY_DELETE) begin
              if (cells_q[cellIdx] != 5'd0) begin
                cells_d[cellIdx] = 5'd0;
                count_d          = count_q - 5'd1;
                accept_d         = 1'b1;
              end
            end
          end
        end
      end
      CLEAR: begin
        cells_d[sweepIdx_q] = 5'd0;
        if (cells_q[sweepIdx_q] != 5'd0) begin
          count_d = count_q - 5'd1;
        end
        if (sweepIdx_q == 5'(NUM_CELLS - 1)) begin
          state_d    = IDLE;
          sweepIdx_d = '0;
          count_d    = 5'd0;
        end else begin
          sweepIdx_d = sweepIdx_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    full_d = (count_d == 5'(NUM_CELLS));
  end

  // Grid, status and FSM state registers.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      sweepIdx_q <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      accept_q   <= 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) begin
        cells_q[i] <= 5'd0;
      end
    end else begin
      state_q    <= state_d;
      sweepIdx_q <= sweepIdx_d;
      count_q    <= count_d;
      full_q     <= full_d;
      accept_q   <= accept_d;
      cells_q    <= cells_d;
    end
  end

  // Combinational read port; out-of-range coordinates read as blank.
  always_comb begin
    rd_letter = 5'd0;
    if (rd_row < 3'(GRID_DIM) && rd_col < 3'(GRID_DIM)) begin
      rd_letter = cells_q[5'(rd_row) * 5'(GRID_DIM) + 5'(rd_col)];
    end
  end

  assign filled_count = count_q;
  assign grid_full    = full_q;
  assign busy         = (state_q == CLEAR);
  assign key_accept   = accept_q;

endmodule

// File: tb/tb_crossword_grid_entry.sv
// Directed bench for crossword_grid_entry: table of single key presses plus
// hand sequences for latency, no-release change, clear sweep and mid-sweep reset.
module tb_crossword_grid_entry;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic [9:0] highlightX;
  logic [9:0] highlightY;
  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic [4:0] rd_letter;
  logic [4:0] filled_count;
  logic       grid_full;
  logic       busy;
  logic       key_accept;

  int checks;
  int errors;
  int pulseCount;
  int expGrid [25];

  typedef struct {
    string      name;
    logic [7:0] key;
    logic [9:0] x;
    logic [9:0] y;
    int         row;
    int         col;
    int         expLetter;
    int         expCount;
    int         expPulses;
  } vec_t;

  vec_t vecs [10];

  crossword_grid_entry dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .highlightX  (highlightX),
    .highlightY  (highlightY),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_letter   (rd_letter),
    .filled_count(filled_count),
    .grid_full   (grid_full),
    .busy        (busy),
    .key_accept  (key_accept)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    @(negedge frame_clk);
    if (key_accept) pulseCount++;
  endtask

  task automatic applyStimulus(input logic [7:0] key, input logic [9:0] x, input logic [9:0] y);
    keycode    = key;
    highlightX = x;
    highlightY = y;
  endtask

  task automatic readCell(input int row, input int col, output int letter);
    rd_row = 3'(row);
    rd_col = 3'(col);
    #1;
    letter = int'(rd_letter);
  endtask

  task automatic pressKey(input logic [7:0] key, input logic [9:0] x, input logic [9:0] y, input int hold);
    applyStimulus(key, x, y);
    repeat (hold) tick();
    applyStimulus(8'h00, x, y);
    repeat (3) tick();
  endtask

  initial begin
    int v;
    checks = 0;
    errors = 0;
    pulseCount = 0;

    vecs[0] = '{"overwrite_00",  8'h04, 10'd4,   10'd80,  0, 0, 1,  1, 1};
    vecs[1] = '{"write_22",      8'h1D, 10'd164, 10'd240, 2, 2, 26, 2, 1};
    vecs[2] = '{"bksp_22",       8'h2A, 10'd164, 10'd240, 2, 2, 0,  1, 1};
    vecs[3] = '{"bksp_blank_22", 8'h2A, 10'd164, 10'd240, 2, 2, 0,  1, 0};
    vecs[4] = '{"misaligned_x",  8'h04, 10'd5,   10'd80,  0, 0, 1,  1, 0};
    vecs[5] = '{"offgrid_x404",  8'h04, 10'd404, 10'd80,  0, 4, 0,  1, 0};
    vecs[6] = '{"delete_00",     8'h4C, 10'd4,   10'd80,  0, 0, 0,  0, 1};
    vecs[7] = '{"arrow_ignored", 8'h51, 10'd4,   10'd80,  0, 0, 0,  0, 0};
    vecs[8] = '{"write_44_z",    8'h1D, 10'd324, 10'd400, 4, 4, 26, 1, 1};
    vecs[9] = '{"overwrite_44",  8'h05, 10'd324, 10'd400, 4, 4, 2,  1, 1};

    applyStimulus(8'h00, 10'd4, 10'd80);
    rd_row = 3'd0;
    rd_col = 3'd0;
    Reset  = 1'b1;
    repeat (2) tick();
    Reset = 1'b0;
    tick();

    // Reset state
    readCell(0, 0, v);
    checkOutput("reset_cell00", v, 0);
    checkOutput("reset_count", filled_count, 0);
    checkOutput("reset_full", grid_full, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_accept", key_accept, 0);

    // Two-edge latency with a held key, then release
    pulseCount = 0;
    applyStimulus(8'h04, 10'd4, 10'd80);
    tick();
    readCell(0, 0, v);
    checkOutput("lat_edge1_cell", v, 0);
    tick();
    readCell(0, 0, v);
    checkOutput("lat_edge2_cell", v, 1);
    checkOutput("lat_edge2_accept", key_accept, 1);
    repeat (8) tick();
    applyStimulus(8'h00, 10'd4, 10'd80);
    repeat (3) tick();
    checkOutput("lat_pulses", pulseCount, 1);
    checkOutput("lat_count", filled_count, 1);

    // Table of single presses
    for (int i = 0; i < 10; i++) begin
      pulseCount = 0;
      pressKey(vecs[i].key, vecs[i].x, vecs[i].y, 4);
      readCell(vecs[i].row, vecs[i].col, v);
      checkOutput({vecs[i].name, "_letter"}, v, vecs[i].expLetter);
      checkOutput({vecs[i].name, "_count"}, filled_count, vecs[i].expCount);
      checkOutput({vecs[i].name, "_pulses"}, pulseCount, vecs[i].expPulses);
    end

    // Key change without release at (2,2)
    pulseCount = 0;
    applyStimulus(8'h1D, 10'd164, 10'd240);
    repeat (2) tick();
    readCell(2, 2, v);
    checkOutput("norel_first", v, 26);
    applyStimulus(8'h06, 10'd164, 10'd240);
    repeat (2) tick();
    readCell(2, 2, v);
    checkOutput("norel_second", v, 3);
    applyStimulus(8'h00, 10'd164, 10'd240);
    repeat (3) tick();
    checkOutput("norel_count", filled_count, 2);
    checkOutput("norel_pulses", pulseCount, 2);

    // Fill every cell
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        expGrid[r * 5 + c] = r * 5 + c + 1;
        pressKey(8'(8'h04 + r * 5 + c), 10'(4 + 80 * c), 10'(80 + 80 * r), 2);
      end
    end
    checkOutput("fill_count", filled_count, 25);
    checkOutput("fill_full", grid_full, 1);
    for (int i = 0; i < 25; i++) begin
      readCell(i / 5, i % 5, v);
      checkOutput($sformatf("fill_cell%0d", i), v, expGrid[i]);
    end
    readCell(5, 0, v);
    checkOutput("rd_row_oob", v, 0);
    readCell(0, 7, v);
    checkOutput("rd_col_oob", v, 0);

    // Escape sweep with a key pressed and held through it
    pulseCount = 0;
    applyStimulus(8'h29, 10'd4, 10'd80);
    tick();
    checkOutput("esc_edge1_busy", busy, 0);
    tick();
    checkOutput("esc_edge2_busy", busy, 1);
    checkOutput("esc_edge2_accept", key_accept, 1);
    pulseCount = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 1) applyStimulus(8'h00, 10'd4, 10'd80);
      if (k == 3) applyStimulus(8'h05, 10'd4, 10'd80);
      tick();
      readCell((k - 1) / 5, (k - 1) % 5, v);
      checkOutput($sformatf("sweep_cleared%0d", k - 1), v, 0);
      if (k < 25) begin
        readCell(k / 5, k % 5, v);
        checkOutput($sformatf("sweep_kept%0d", k), v, expGrid[k]);
        checkOutput($sformatf("sweep_busy%0d", k), busy, 1);
      end
    end
    checkOutput("sweep_end_busy", busy, 0);
    checkOutput("sweep_end_count", filled_count, 0);
    checkOutput("sweep_end_full", grid_full, 0);
    repeat (5) tick();
    applyStimulus(8'h00, 10'd4, 10'd80);
    repeat (3) tick();
    readCell(0, 0, v);
    checkOutput("held_key_cell00", v, 0);
    checkOutput("held_key_count", filled_count, 0);
    checkOutput("sweep_pulses", pulseCount, 0);

    // Reset in the middle of a sweep
    pressKey(8'h04, 10'd4, 10'd80, 2);
    pressKey(8'h1D, 10'd324, 10'd400, 2);
    checkOutput("pre_esc_count", filled_count, 2);
    applyStimulus(8'h29, 10'd4, 10'd80);
    repeat (2) tick();
    applyStimulus(8'h00, 10'd4, 10'd80);
    repeat (10) tick();
    checkOutput("midsweep_busy", busy, 1);
    Reset = 1'b1;
    readCell(4, 4, v);
    checkOutput("rst_mid_cell44", v, 0);
    checkOutput("rst_mid_count", filled_count, 0);
    checkOutput("rst_mid_full", grid_full, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_accept", key_accept, 0);
    @(negedge frame_clk);
    Reset = 1'b0;
    tick();
    applyStimulus(8'h04, 10'd4, 10'd80);
    repeat (2) tick();
    readCell(0, 0, v);
    checkOutput("post_rst_cell00", v, 1);
    checkOutput("post_rst_accept", key_accept, 1);
    applyStimulus(8'h00, 10'd4, 10'd80);
    tick();
    checkOutput("post_rst_count", filled_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crossword_grid_entry.md
Name: crossword_grid_entry

Overview:
Letter-storage stage directly downstream of the cursor-highlight block. It consumes the highlight cell position (highlightX/highlightY) and the USB keyboard keycode. It writes typed letters A–Z into a 5x5 grid register file, clears cells on Backspace/Delete, and clears the whole grid on Escape. A combinational read port feeds the VGA colour mapper, and fill status is exported for win/complete logic.

Parameters:
GRID_DIM, 5, cells per row/column
CELL_SIZE, 80, pixel pitch of one cell
X_ORIGIN, 4, highlightX of column 0
Y_ORIGIN, 80, highlightY of row 0

Ports:
frame_clk  in  1  frame-rate clock; all state updates on its rising edge
Reset  in  1  asynchronous, active-high reset
keycode  in  8  current USB HID keycode; 0x00 = no key
highlightX  in  10  cursor cell X pixel from highlight block
highlightY  in  10  cursor cell Y pixel from highlight block
rd_row  in  3  read-port row, 0..4
rd_col  in  3  read-port column, 0..4
rd_letter  out  5  letter at (rd_row, rd_col): 0 = blank, 1..26 = A..Z; 0 if row/col > 4
filled_count  out  5  number of non-blank cells, 0..25
grid_full  out  1  filled_count == 25
busy  out  1  high while a clear-all sweep is running
key_accept  out  1  one-cycle pulse when a key event modifies the grid

Behaviour:
- Reset (async, any time, including mid-sweep):
  - all 25 cells = 0, filled_count = 0, grid_full = 0, busy = 0, key_accept = 0
  - prev_key = 0x00, FSM = IDLE, stage-1 registers cleared
- Key event detection:
  - prev_key registers keycode every cycle.
  - event = (keycode != 0) && (keycode != prev_key).
  - A held key gives exactly one event. A change A→B with no release gives an event for B.
- Position decode, combinational on the stage-1 captured X/Y:
  - col = k where X == X_ORIGIN + k*CELL_SIZE, k in 0..4; same for row with Y_ORIGIN.
  - Implement as an equality-compare chain, not a divider.
  - No exact match → pos_valid = 0.
- Stage 1, cycle N+1 after the event cycle N: register the key, X, Y, and the event flag.
- Stage 2, cycle N+2, acting on the stage-1 contents:
  - keycode 0x04..0x1D with pos_valid: cell = keycode − 3.
    - Blank → letter: filled_count +1.
    - Letter → letter: filled_count unchanged.
    - key_accept = 1.
  - keycode 0x2A or 0x4C with pos_valid: cell = 0.
    - If the cell was non-blank: filled_count −1, key_accept = 1.
    - Clearing a blank cell: no change, no pulse.
  - keycode 0x29 (Escape): enter CLEAR, busy = 1, key_accept = 1. pos_valid is ignored.
  - All other keycodes (including arrows 0x4F–0x52), or pos_valid = 0: no write, no pulse.
- Latency: rd_letter reflects a write on the cycle after stage 2, i.e. 2 frame_clk edges after the keycode change is sampled.
- FSM:
  - IDLE → CLEAR on an Escape decode in stage 2.
  - CLEAR: sweep index 0..24, zeroing one cell per cycle in row-major order (idx = row*5 + col).
  - CLEAR → IDLE after index 24 is cleared, so the sweep lasts 25 cycles.
  - filled_count = 0 and busy = 0 on the IDLE return cycle.
  - While in CLEAR: new events are dropped (not queued), and stage 1 is flushed.
  - prev_key keeps tracking, so a key held through the sweep does not fire afterwards.
- grid_full is registered alongside filled_count (same cycle).
- rd_letter is purely combinational from the cell array; there is no read latency.

Test Plan:
- Reset, highlight (4,80), keycode 0x04 for 10 cycles, then 0x00 → cell (0,0) = 1 exactly 2 edges after the change, filled_count = 1, one key_accept pulse only.
- Highlight (164,240), key 0x1D, then 0x06 with no release → cell (2,2) = 26 then 3; filled_count stays at 1 after the overwrite; two pulses.
- Same cell, key 0x2A → cell = 0, filled_count = 0, pulse. A second 0x2A press → no change, no pulse.
- Highlight (5,80) (misaligned) or (404,80), key 0x04 → no write, no pulse, filled_count unchanged.
- Fill all 25 cells → grid_full = 1. Press 0x29 → busy high for 25 cycles, cells zeroed in row-major order, filled_count = 0, grid_full = 0. A 0x05 press during the sweep is ignored.
- Assert Reset at sweep index 10 → all outputs at reset values immediately. The next 0x04 press after deassert writes normally.
